// File: rtl/priority_scan_enc_v_pkg.sv
// -----------------------------------------------------------------------------
// priority_scan_enc_v_pkg
//
// Purpose:
//   Shared definitions for the priority scan encoder slice: the scan FSM
//   state encoding and the index-width helper used to size the code output.
//
// Contents:
//   state_e       ST_IDLE (no pending bits) / ST_SCAN (pending bits, beat valid)
//   idx_width()   number of bits needed to express an index 0..width-1
// -----------------------------------------------------------------------------
package priority_scan_enc_v_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_e;

    // Index width for a vector of 'width' request lines. The vector is
    // at least two bits wide, so this is always at least 1.
    function automatic int idx_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/priority_scan_enc_v_enc_n.sv
// -----------------------------------------------------------------------------
// priority_enc_n_v
//
// Purpose:
//   Purely combinational N-to-log2(N) priority encoder, the parametrised
//   generalisation of the 4-to-2 encoder. Reports the index of the
//   top-priority set bit and whether any bit is set.
//
// Parameters:
//   WIDTH      request vector width (>= 2)
//   MSB_FIRST  1: highest index wins; 0: bit 0 wins
//
// Ports:
//   i_vec  in   WIDTH   vector to encode
//   o_idx  out  IDX_W   top-priority index (0 when nothing is set)
//   o_any  out  1       at least one bit of i_vec is set
// -----------------------------------------------------------------------------
module priority_enc_n_v
    import priority_scan_enc_v_pkg::*;
#(
    parameter int   WIDTH     = 8,
    parameter bit   MSB_FIRST = 1'b1,
    localparam int  IDX_W     = idx_width(WIDTH)
) (
    input  logic [WIDTH-1:0] i_vec,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    // The loop walks from lowest to highest priority so that the last set
    // bit visited (the highest priority one) determines the index.
    always_comb begin
        o_idx = '0;
        o_any = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (MSB_FIRST) begin
                if (i_vec[i]) begin
                    o_idx = IDX_W'(i);
                    o_any = 1'b1;
                end
            end else begin
                if (i_vec[WIDTH-1-i]) begin
                    o_idx = IDX_W'(WIDTH-1-i);
                    o_any = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/priority_scan_enc_v.sv
// -----------------------------------------------------------------------------
// priority_scan_enc_v
//
// Purpose:
//   Sequential priority scanner. Captures a WIDTH-bit request vector and
//   emits the index of each set bit, one per accepted beat, in priority
//   order, clearing each bit as its beat is accepted.
//
// Parameters:
//   WIDTH      request vector width (>= 2)
//   MSB_FIRST  1: highest index first; 0: bit 0 first
//   IDX_W      derived index width (not overridable)
//
// Ports:
//   i_clk        in   1      clock, rising edge
//   i_rst_n      in   1      asynchronous active-low reset
//   i_code       in   WIDTH  request vector, sampled on an accepted load
//   i_load       in   1      load request
//   o_load_rdy   out  1      a load is accepted this cycle if i_load = 1
//   i_flush      in   1      synchronous abort of the pending vector
//   o_code       out  IDX_W  index of the current top-priority set bit
//   o_valid      out  1      o_code is valid
//   i_ready      in   1      consumer takes o_code this cycle
//   o_last       out  1      current beat is the final pending bit
//   o_zero       out  1      one-cycle pulse: the loaded vector was zero
//   o_dbg_state  out  1      current scan FSM state (ST_IDLE / ST_SCAN)
//
// Handshake: a beat transfers on a rising edge where o_valid = 1 and
// i_ready = 1. While o_valid = 1 and i_ready = 0, o_code and o_last hold
// and the pending vector is untouched. o_valid never drops without a
// transfer except on i_flush or reset. A load transfers on a rising edge
// where i_load = 1 and o_load_rdy = 1; o_load_rdy depends combinationally
// on i_ready so the next vector can follow the final beat with no bubble.
// -----------------------------------------------------------------------------
module priority_scan_enc_v
    import priority_scan_enc_v_pkg::*;
#(
    parameter int   WIDTH     = 8,
    parameter bit   MSB_FIRST = 1'b1,
    localparam int  IDX_W     = idx_width(WIDTH)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_code,
    input  logic             i_load,
    output logic             o_load_rdy,
    input  logic             i_flush,
    output logic [IDX_W-1:0] o_code,
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_last,
    output logic             o_zero,
    output logic             o_dbg_state
);

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    state_e           state_q, state_d;
    logic [WIDTH-1:0] vec_q,   vec_d;
    logic [IDX_W-1:0] code_q,  code_d;
    logic             valid_q, valid_d;
    logic             last_q,  last_d;
    logic             zero_q,  zero_d;

    logic             beat_acc;
    logic             load_rdy;
    logic             load_acc;
    logic [IDX_W-1:0] nxt_idx;
    logic             nxt_any;
    logic             nxt_single;

    // -------------------------------------------------------------------------
    // Handshake qualification
    // -------------------------------------------------------------------------
    assign beat_acc = valid_q & i_ready;
    // Ready when idle, or when the final pending bit is leaving this cycle.
    assign load_rdy = (state_q == ST_IDLE) | (valid_q & last_q & i_ready);
    assign load_acc = i_load & load_rdy;

    // -------------------------------------------------------------------------
    // Next pending vector. Flush dominates load, load dominates a beat
    // (a load can only coincide with the final beat, whose bit is being
    // dropped anyway).
    // -------------------------------------------------------------------------
    always_comb begin
        vec_d = vec_q;
        if (i_flush) begin
            vec_d = '0;
        end else if (load_acc) begin
            vec_d = i_code;
        end else if (beat_acc) begin
            vec_d = vec_q & ~(WIDTH'(1) << code_q);
        end
    end

    // The encoder looks at the next vector so that o_code, o_valid and
    // o_last can all be registered and still appear the cycle after a
    // load or a beat.
    priority_enc_n_v #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_enc (
        .i_vec (vec_d),
        .o_idx (nxt_idx),
        .o_any (nxt_any)
    );

    // Exactly one bit set: clearing the lowest set bit leaves nothing.
    assign nxt_single = nxt_any & ((vec_d & (vec_d - WIDTH'(1))) == '0);

    always_comb begin
        state_d = nxt_any ? ST_SCAN : ST_IDLE;
        valid_d = nxt_any;
        code_d  = nxt_idx;
        last_d  = nxt_single;
        zero_d  = ~i_flush & load_acc & (i_code == '0);
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            vec_q   <= '0;
            code_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            zero_q  <= zero_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign o_load_rdy  = load_rdy;
    assign o_code      = code_q;
    assign o_valid     = valid_q;
    assign o_last      = last_q;
    assign o_zero      = zero_q;
    assign o_dbg_state = state_q;

endmodule

// File: tb/tb_priority_scan_enc_v.sv
// -----------------------------------------------------------------------------
// tb_priority_scan_enc_v
//
// Two instances share stimulus: WIDTH=8/MSB_FIRST=1 and WIDTH=5/MSB_FIRST=0.
// Each has a reference model holding the pending indices as a queue in
// priority order; the compare process checks every cycle against it.
// -----------------------------------------------------------------------------
module tb_priority_scan_enc_v;

    // -------------------------------------------------------------------------
    // Clock / reset and DUT signals
    // -------------------------------------------------------------------------
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] code_in = 8'h00;
    logic       load = 1'b0;
    logic       flush = 1'b0;
    logic       ready = 1'b0;

    logic       load_rdy8, valid8, last8, zero8, state8;
    logic [2:0] code8;
    logic       load_rdy5, valid5, last5, zero5, state5;
    logic [2:0] code5;

    always #5 clk = ~clk;

    priority_scan_enc_v #(.WIDTH(8), .MSB_FIRST(1'b1)) dut8 (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_code      (code_in),
        .i_load      (load),
        .o_load_rdy  (load_rdy8),
        .i_flush     (flush),
        .o_code      (code8),
        .o_valid     (valid8),
        .i_ready     (ready),
        .o_last      (last8),
        .o_zero      (zero8),
        .o_dbg_state (state8)
    );

    priority_scan_enc_v #(.WIDTH(5), .MSB_FIRST(1'b0)) dut5 (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_code      (code_in[4:0]),
        .i_load      (load),
        .o_load_rdy  (load_rdy5),
        .i_flush     (flush),
        .o_code      (code5),
        .o_valid     (valid5),
        .i_ready     (ready),
        .o_last      (last5),
        .o_zero      (zero5),
        .o_dbg_state (state5)
    );

    // -------------------------------------------------------------------------
    // Scoreboard counters and check helper
    // -------------------------------------------------------------------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // -------------------------------------------------------------------------
    // Reference model: pending indices in the order they must be emitted
    // -------------------------------------------------------------------------
    int m8_q[$];
    int m5_q[$];
    bit m8_zero = 1'b0;
    bit m5_zero = 1'b0;

    always @(posedge clk or negedge rst_n) begin : model
        bit rdy8, rdy5;
        if (!rst_n) begin
            m8_q.delete();
            m5_q.delete();
            m8_zero = 1'b0;
            m5_zero = 1'b0;
        end else begin
            rdy8 = (m8_q.size() == 0) || (m8_q.size() == 1 && ready);
            rdy5 = (m5_q.size() == 0) || (m5_q.size() == 1 && ready);
            m8_zero = 1'b0;
            m5_zero = 1'b0;
            if (flush) begin
                m8_q.delete();
            end else if (load && rdy8) begin
                m8_q.delete();
                for (int k = 7; k >= 0; k--) if (code_in[k]) m8_q.push_back(k);
                m8_zero = (code_in == 8'h00);
            end else if (m8_q.size() != 0 && ready) begin
                void'(m8_q.pop_front());
            end
            if (flush) begin
                m5_q.delete();
            end else if (load && rdy5) begin
                m5_q.delete();
                for (int k = 0; k < 5; k++) if (code_in[k]) m5_q.push_back(k);
                m5_zero = (code_in[4:0] == 5'b00000);
            end else if (m5_q.size() != 0 && ready) begin
                void'(m5_q.pop_front());
            end
        end
    end

    // -------------------------------------------------------------------------
    // Compare process: every cycle, away from the active edge
    // -------------------------------------------------------------------------
    always @(negedge clk) begin
        chk("valid8", int'(valid8), int'(m8_q.size() != 0));
        chk("state8", int'(state8), int'(m8_q.size() != 0));
        chk("zero8", int'(zero8), int'(m8_zero));
        chk("load_rdy8", int'(load_rdy8),
            int'((m8_q.size() == 0) || (m8_q.size() == 1 && ready)));
        if (m8_q.size() != 0) begin
            chk("code8", int'(code8), m8_q[0]);
            chk("last8", int'(last8), int'(m8_q.size() == 1));
        end
        chk("valid5", int'(valid5), int'(m5_q.size() != 0));
        chk("state5", int'(state5), int'(m5_q.size() != 0));
        chk("zero5", int'(zero5), int'(m5_zero));
        chk("load_rdy5", int'(load_rdy5),
            int'((m5_q.size() == 0) || (m5_q.size() == 1 && ready)));
        if (m5_q.size() != 0) begin
            chk("code5", int'(code5), m5_q[0]);
            chk("last5", int'(last5), int'(m5_q.size() == 1));
            chk("code5_range", int'(code5 <= 3'd4), 1);
        end
    end

    // -------------------------------------------------------------------------
    // Driver helpers
    // -------------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    int seq8[4] = '{7, 5, 2, 0};
    int seq5[3] = '{1, 2, 4};

    initial begin
        // Reset
        tick();
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_valid", int'(valid8), 0);
        chk("rst_code", int'(code8), 0);
        chk("rst_last", int'(last8), 0);
        chk("rst_zero", int'(zero8), 0);
        chk("rst_load_rdy", int'(load_rdy8), 1);
        tick();

        // Straight scan, consumer always ready
        ready = 1'b1; load = 1'b1; code_in = 8'hA5;
        tick();
        load = 1'b0; code_in = 8'h00;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t1_code", int'(code8), seq8[k]);
            chk("t1_last", int'(last8), int'(k == 3));
            tick();
        end
        @(negedge clk);
        chk("t1_done", int'(valid8), 0);
        tick();

        // Back-pressure: three stalled cycles on the first beat
        ready = 1'b0; load = 1'b1; code_in = 8'hA5;
        tick();
        load = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t2_hold_code", int'(code8), 7);
            chk("t2_hold_last", int'(last8), 0);
            tick();
        end
        ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t2_code", int'(code8), seq8[k]);
            tick();
        end
        @(negedge clk);
        chk("t2_done", int'(valid8), 0);
        tick();

        // All-zero vector
        load = 1'b1; code_in = 8'h00;
        tick();
        load = 1'b0;
        @(negedge clk);
        chk("t3_zero", int'(zero8), 1);
        chk("t3_valid", int'(valid8), 0);
        chk("t3_load_rdy", int'(load_rdy8), 1);
        tick();
        @(negedge clk);
        chk("t3_zero_pulse", int'(zero8), 0);
        tick();

        // Load on the final beat: no bubble
        load = 1'b1; code_in = 8'h02;
        tick();
        code_in = 8'h80;
        @(negedge clk);
        chk("t4_code_a", int'(code8), 1);
        chk("t4_last_a", int'(last8), 1);
        chk("t4_rdy_a", int'(load_rdy8), 1);
        tick();
        load = 1'b0;
        @(negedge clk);
        chk("t4_code_b", int'(code8), 7);
        chk("t4_valid_b", int'(valid8), 1);
        tick();
        @(negedge clk);
        chk("t4_done", int'(valid8), 0);
        tick();

        // Load mid-scan is ignored
        ready = 1'b0; load = 1'b1; code_in = 8'h81;
        tick();
        code_in = 8'h0F; ready = 1'b1;
        @(negedge clk);
        chk("t4_mid_code", int'(code8), 7);
        chk("t4_mid_rdy", int'(load_rdy8), 0);
        tick();
        load = 1'b0;
        @(negedge clk);
        chk("t4_mid_next", int'(code8), 0);
        chk("t4_mid_last", int'(last8), 1);
        tick();
        @(negedge clk);
        chk("t4_mid_done", int'(valid8), 0);
        tick();

        // Flush with a simultaneous load
        load = 1'b1; code_in = 8'hFF;
        tick();
        load = 1'b0;
        tick();
        tick();
        flush = 1'b1; load = 1'b1; code_in = 8'h3C;
        @(negedge clk);
        chk("t5_code_pre", int'(code8), 5);
        tick();
        flush = 1'b0; load = 1'b0;
        @(negedge clk);
        chk("t5_valid", int'(valid8), 0);
        chk("t5_last", int'(last8), 0);
        chk("t5_state", int'(state8), 0);
        tick();
        @(negedge clk);
        chk("t5_no_load", int'(valid8), 0);
        tick();

        // Asynchronous reset mid-scan
        load = 1'b1; code_in = 8'hFF;
        tick();
        load = 1'b0;
        tick();
        #1;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_valid", int'(valid8), 0);
        chk("t5_rst_code", int'(code8), 0);
        chk("t5_rst_last", int'(last8), 0);
        chk("t5_rst_state", int'(state8), 0);
        chk("t5_rst_valid5", int'(valid5), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        // LSB-first, five-bit instance
        load = 1'b1; code_in = 8'b0001_0110;
        tick();
        load = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t6_code5", int'(code5), seq5[k]);
            chk("t6_last5", int'(last5), int'(k == 2));
            tick();
        end
        @(negedge clk);
        chk("t6_done5", int'(valid5), 0);
        tick();

        // Randomised traffic against the model
        for (int n = 0; n < 3000; n++) begin
            load    = ($urandom_range(0, 2) == 0);
            code_in = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            ready   = ($urandom_range(0, 3) != 0);
            flush   = ($urandom_range(0, 40) == 0);
            tick();
        end
        load = 1'b0; flush = 1'b0; ready = 1'b1;
        repeat (12) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
